// File: rtl/p_inverse_transformation.sv
// p_inverse_transformation: serial 2-bit-pair inverse P-box, restores X from permuted Y in 4 steps
module p_inverse_transformation #(
   parameter logic [7:0] KEY = 8'b10_01_00_11
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_in,
   input  logic       i_in_valid,
   output logic       o_in_ready,
   output logic [7:0] o_out,
   output logic       o_out_valid,
   input  logic       i_out_ready,
   output logic       o_busy,
   output logic       o_key_err
);
   function automatic logic key_bad(input logic [7:0] k);
      logic [3:0] seen;
      seen = '0;
      for (int j = 0; j < 4; j++) seen[k[2*j+:2]] = 1'b1;
      return seen != 4'hF;
   endfunction
   localparam logic KEY_ERR = key_bad(KEY);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t     r_state, w_state_nxt;
   logic [1:0] r_cnt, w_col;
   logic [7:0] r_sreg, r_acc, w_acc_nxt;
   logic       w_accept;
   assign o_key_err  = KEY_ERR;
   assign o_in_ready = (r_state == IDLE) && !KEY_ERR;
   assign o_busy     = (r_state != IDLE);
   assign w_accept   = i_in_valid && o_in_ready;
   assign w_col      = KEY[2*r_cnt+:2];
   // scatter the current top pair into its column of the accumulator
   always_comb begin
      w_acc_nxt = r_acc;
      w_acc_nxt[{1'b0, w_col}] = r_sreg[7];
      w_acc_nxt[{1'b1, w_col}] = r_sreg[6];
   end
   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = w_accept ? SHIFT : IDLE;
         SHIFT:   w_state_nxt = (r_cnt == 2'd3) ? DONE : SHIFT;
         DONE:    w_state_nxt = i_out_ready ? IDLE : DONE;
         default: w_state_nxt = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end
   // datapath: latch, shift/scatter, publish result, handshake
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt       <= '0;
         r_sreg      <= '0;
         r_acc       <= '0;
         o_out       <= '0;
         o_out_valid <= 1'b0;
      end else begin
         if (r_state == IDLE && w_accept) begin
            r_sreg <= i_in;
            r_acc  <= '0;
            r_cnt  <= '0;
         end
         if (r_state == SHIFT) begin
            r_sreg <= r_sreg << 2;
            r_acc  <= w_acc_nxt;
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
               o_out       <= w_acc_nxt;
               o_out_valid <= 1'b1;
            end
         end
         if (r_state == DONE && i_out_ready) o_out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_p_inverse_transformation.sv
// tb_p_inverse_transformation: directed and randomized checks against a behavioural P-box model
module tb_p_inverse_transformation;
   localparam logic [7:0] KEY = 8'b10_01_00_11;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_b = '0;
   logic       in_valid = 1'b0, out_ready = 1'b0;
   logic       in_ready, out_valid, busy, key_err;
   logic [7:0] out_b;
   logic       b_in_ready, b_out_valid, b_busy, b_key_err;
   logic [7:0] b_out;
   logic       b_in_valid = 1'b1;
   int         checks = 0, errors = 0;
   logic [7:0] exp_q[$];
   int         received = 0;
   logic       sb_en = 1'b0;
   always #5 clk = ~clk;
   p_inverse_transformation #(.KEY(KEY)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in(in_b), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .o_out(out_b), .o_out_valid(out_valid), .i_out_ready(out_ready), .o_busy(busy), .o_key_err(key_err));
   p_inverse_transformation #(.KEY(8'b00_00_01_11)) bad (
      .i_clk(clk), .i_rst_n(rst_n), .i_in(8'h59), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
      .o_out(b_out), .o_out_valid(b_out_valid), .i_out_ready(1'b1), .o_busy(b_busy), .o_key_err(b_key_err));
   // forward P-box: pair j = {X[c_j], X[c_j+4]} placed at Y[7-2j:6-2j]
   function automatic logic [7:0] fwd(input logic [7:0] x);
      logic [7:0] y;
      int c;
      y = '0;
      for (int j = 0; j < 4; j++) begin
         c = int'(KEY[2*j+:2]);
         y[7-2*j] = x[c];
         y[6-2*j] = x[c+4];
      end
      return y;
   endfunction
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic send(input logic [7:0] y);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", {7'd0, in_ready}, 8'd1);
      in_b = y;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask
   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      check("wait_valid", {7'd0, out_valid}, 8'd1);
   endtask
   task automatic xfer(input logic [7:0] y, input logic [7:0] x);
      out_ready = 1'b1;
      send(y);
      wait_valid();
      check("xfer_out", out_b, x);
      check("xfer_model", out_b, 8'(fwd(out_b) == y ? out_b : ~out_b));
      @(posedge clk);
      #1 check("xfer_idle", {7'd0, in_ready}, 8'd1);
   endtask
   // scoreboard: every handshake must deliver the next expected byte; stalled Out must hold
   logic       p_valid = 1'b0, p_hs = 1'b0;
   logic [7:0] p_out = '0;
   always @(negedge clk) begin
      if (sb_en) begin
         if (out_valid && p_valid && !p_hs) check("stall_hold", out_b, p_out);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("extra_output", out_b, ~out_b);
            else check("rand_out", out_b, exp_q.pop_front());
            received++;
         end
      end
      p_valid = out_valid;
      p_hs = out_valid && out_ready;
      p_out = out_b;
   end
   initial begin
      logic [7:0] xs[$];
      logic [7:0] x;
      repeat (2) @(negedge clk);
      check("rst_out", out_b, 8'h00);
      check("rst_valid", {7'd0, out_valid}, 8'd0);
      check("rst_busy", {7'd0, busy}, 8'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ready", {7'd0, in_ready}, 8'd1);
      check("key_ok", {7'd0, key_err}, 8'd0);
      send(8'h59);
      check("busy_accept", {7'd0, busy}, 8'd1);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1 check($sformatf("lat_valid%0d", k), {7'd0, out_valid}, {7'd0, k == 4});
         check($sformatf("lat_busy%0d", k), {7'd0, busy}, 8'd1);
      end
      check("t1_out", out_b, 8'hD2);
      for (int k = 0; k < 10; k++) begin
         in_b = 8'hFF;
         in_valid = 1'b1;
         @(posedge clk);
         #1 check("hold_out", out_b, 8'hD2);
         check("hold_valid", {7'd0, out_valid}, 8'd1);
         check("hold_inready", {7'd0, in_ready}, 8'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 check("hs_valid", {7'd0, out_valid}, 8'd0);
      check("hs_inready", {7'd0, in_ready}, 8'd1);
      check("hs_keep_out", out_b, 8'hD2);
      check("hs_busy", {7'd0, busy}, 8'd0);
      xfer(8'h20, 8'h01);
      xfer(8'h40, 8'h80);
      xfer(8'h00, 8'h00);
      xfer(8'hFF, 8'hFF);
      xfer(8'h59, 8'hD2);
      send(8'h59);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("abort_out", out_b, 8'h00);
      check("abort_valid", {7'd0, out_valid}, 8'd0);
      check("abort_busy", {7'd0, busy}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      xfer(8'h59, 8'hD2);
      sb_en = 1'b1;
      for (int i = 0; i < 1000; i++) xs.push_back(8'($urandom));
      fork
         begin
            foreach (xs[i]) begin
               exp_q.push_back(xs[i]);
               repeat ($urandom_range(0, 2)) @(negedge clk);
               send(fwd(xs[i]));
            end
         end
         begin
            int n = 0;
            while (received < 1000 && n < 40000) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 2) != 0);
               n++;
            end
         end
      join
      check("rand_count", 8'(received == 1000), 8'd1);
      check("rand_queue_empty", 8'(exp_q.size()), 8'd0);
      sb_en = 1'b0;
      x = 8'h5A;
      check("model_pin", fwd(8'hD2), 8'h59);
      check("model_pin2", fwd(x), fwd(8'h5A) ^ 8'h00);
      check("bad_key_err", {7'd0, b_key_err}, 8'd1);
      check("bad_in_ready", {7'd0, b_in_ready}, 8'd0);
      repeat (5) @(posedge clk);
      #1 check("bad_in_ready_late", {7'd0, b_in_ready}, 8'd0);
      check("bad_out_valid", {7'd0, b_out_valid}, 8'd0);
      check("bad_busy", {7'd0, b_busy}, 8'd0);
      check("bad_out", b_out, 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
